register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of each register and of the data ports.
REQ-002 Parameter: ADDR_WIDTH, 5, register-number width; the file holds 2**ADDR_WIDTH registers (32 by default).
REQ-003 Port: clock  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset, sampled on the rising clock edge.
REQ-005 Port: read_reg_num_1  input  ADDR_WIDTH  register number for read port 1.
REQ-006 Port: read_reg_num_2  input  ADDR_WIDTH  register number for read port 2.
REQ-007 Port: write_reg_num  input  ADDR_WIDTH  destination register number.
REQ-008 Port: write_data  input  DATA_WIDTH  data to write.
REQ-009 Port: regWrite  input  1  write enable, active-high.
REQ-010 Port: read_data_1  output  DATA_WIDTH  contents selected by read_reg_num_1.
REQ-011 Port: read_data_2  output  DATA_WIDTH  contents selected by read_reg_num_2.

Function
REQ-012 The block SHALL contain 2**ADDR_WIDTH registers, each DATA_WIDTH bits wide, indexed 0 to 2**ADDR_WIDTH-1.
REQ-013 Register 0 SHALL always read as 0; writes to register 0 SHALL be ignored.
REQ-014 Both read ports SHALL be combinational, with zero latency and no clock dependency; the two ports are fully independent and may address the same register.
REQ-015 On a rising clock edge with reset=1, regWrite=1 and write_reg_num≠0, register[write_reg_num] SHALL take the value of write_data.
REQ-016 With regWrite=0, no register SHALL change.
REQ-017 Write-through bypass: while regWrite=1 and write_reg_num equals a nonzero read_reg_num_x, read_data_x SHALL equal write_data in the same cycle, before the clock edge.
REQ-018 The bypass SHALL apply to each port independently and to both ports at once when both match.
REQ-019 The bypass SHALL be suppressed while reset=0; in that case the outputs show the stored values.
REQ-020 X or undriven write_data with regWrite=1 SHALL be stored as-is; the block does no sanitizing.
REQ-021 Only one write port exists; no other simultaneous-write conditions apply.

Reset
REQ-022 On a rising edge with reset=0, every register i SHALL load the value i, zero-extended to DATA_WIDTH (register 0 = 0, register 17 = 32'h00000011).
REQ-023 Reset SHALL take priority over any write in the same cycle.
REQ-024 Reset asserted in the middle of a write sequence SHALL discard that cycle's write; writes resume on the first edge with reset=1.
REQ-025 Before the first reset edge, register contents are undefined, except register 0, which reads 0.
REQ-026 Read outputs SHALL reflect reset values combinationally after the reset edge, with no extra cycles.

Verification
REQ-027 Reset one cycle, then read_reg_num_1=17, read_reg_num_2=18 -> read_data_1=32'h00000011, read_data_2=32'h00000012.
REQ-028 regWrite=1, write_reg_num=2, write_data=32'h0002FA41, one edge, regWrite=0, read reg 2 on both ports -> both read 32'h0002FA41; reg 17 unchanged at 32'h00000011.
REQ-029 regWrite=1, write_reg_num=0, write_data=32'hFFFFFFFF, one edge, read reg 0 -> read 0 both before and after the edge, bypass included.
REQ-030 Before the edge: regWrite=1, write_reg_num=5, write_data=32'hDEADBEEF, read_reg_num_1=5, read_reg_num_2=6 -> read_data_1=32'hDEADBEEF (bypass), read_data_2=32'h00000006.
REQ-031 After reg 2 holds 32'h0002FA41: reset=0 with regWrite=1, write_reg_num=3, write_data=32'h12345678, one edge -> reg 2 reads 32'h00000002 and reg 3 reads 32'h00000003.
REQ-032 regWrite=0, write_reg_num=9, write_data=32'hA5A5A5A5, several edges -> reg 9 stays 32'h00000009.

Source files
------------

// File: rtl/register_file.sv
// Register file: 2**ADDR_WIDTH x DATA_WIDTH, two combinational read ports, one write port.
// Register 0 is hardwired to zero; same-cycle writes bypass to matching read ports.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_reg_num_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_num_2,
    input  logic [ADDR_WIDTH-1:0] write_reg_num,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NREG];
    logic [DATA_WIDTH-1:0] regs_d [NREG];

    logic wr_en;
    logic byp_1;
    logic byp_2;

    assign wr_en = regWrite && (write_reg_num != '0);

    // Reset loads each register with its own index and outranks any write.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = DATA_WIDTH'(i);
            end
        end else if (wr_en) begin
            regs_d[write_reg_num] = write_data;
        end
    end

    always_ff @(posedge clock) begin
        regs_q <= regs_d;
    end

    // Bypass only when the pending write would actually commit.
    assign byp_1 = reset && wr_en && (write_reg_num == read_reg_num_1);
    assign byp_2 = reset && wr_en && (write_reg_num == read_reg_num_2);

    always_comb begin
        read_data_1 = '0;
        if (read_reg_num_1 != '0) begin
            read_data_1 = byp_1 ? write_data : regs_q[read_reg_num_1];
        end
    end

    always_comb begin
        read_data_2 = '0;
        if (read_reg_num_2 != '0) begin
            read_data_2 = byp_2 ? write_data : regs_q[read_reg_num_2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus pushes expected read values,
// a negedge monitor pops and compares them against both read ports.
module tb_register_file;

    logic        clock;
    logic        reset;
    logic [4:0]  read_reg_num_1;
    logic [4:0]  read_reg_num_2;
    logic [4:0]  write_reg_num;
    logic [31:0] write_data;
    logic        regWrite;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    typedef struct {
        string       name;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .read_reg_num_1 (read_reg_num_1),
        .read_reg_num_2 (read_reg_num_2),
        .write_reg_num  (write_reg_num),
        .write_data     (write_data),
        .regWrite       (regWrite),
        .read_data_1    (read_data_1),
        .read_data_2    (read_data_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: outputs are combinational, so each cycle's expectation is checked mid-cycle.
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (read_data_1 !== e.e1 || read_data_2 !== e.e2) begin
                bad++;
                $display("FAIL %s: got rd1=%h rd2=%h expected rd1=%h rd2=%h",
                         e.name, read_data_1, read_data_2, e.e1, e.e2);
            end
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [4:0] wn,
                         input logic [31:0] wd, input logic [4:0] r1,
                         input logic [4:0] r2);
        reset          = rst;
        regWrite       = we;
        write_reg_num  = wn;
        write_data     = wd;
        read_reg_num_1 = r1;
        read_reg_num_2 = r2;
    endtask

    task automatic expect_rd(input string name, input logic [31:0] e1,
                             input logic [31:0] e2);
        exp_t e;
        e.name = name;
        e.e1   = e1;
        e.e2   = e2;
        sb.push_back(e);
    endtask

    // Advance to just after the next rising edge before applying new inputs.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        expect_rd("pre_reset_r0", 32'h0, 32'h0);

        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd17, 5'd18);
        expect_rd("reset_17_18", 32'h11, 32'h12);

        for (int i = 0; i < 32; i++) begin
            next_cycle();
            drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
            expect_rd($sformatf("reset_sweep_%0d", i), 32'(i), 32'(31 - i));
        end

        next_cycle();
        drive(1'b1, 1'b1, 5'd2, 32'h0002FA41, 5'd2, 5'd17);
        expect_rd("wr2_bypass", 32'h0002FA41, 32'h11);

        next_cycle();
        drive(1'b1, 1'b0, 5'd2, 32'h0002FA41, 5'd2, 5'd2);
        expect_rd("rd2_both", 32'h0002FA41, 32'h0002FA41);

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd17, 5'd0);
        expect_rd("r17_unchanged", 32'h11, 32'h0);

        next_cycle();
        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        expect_rd("wr0_before", 32'h0, 32'h0);

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        expect_rd("wr0_after", 32'h0, 32'h0);

        next_cycle();
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd6);
        expect_rd("byp_port1", 32'hDEADBEEF, 32'h6);

        next_cycle();
        drive(1'b1, 1'b0, 5'd5, 32'h0, 5'd5, 5'd5);
        expect_rd("rd5_stored", 32'hDEADBEEF, 32'hDEADBEEF);

        next_cycle();
        drive(1'b1, 1'b1, 5'd7, 32'hCAFEF00D, 5'd7, 5'd7);
        expect_rd("byp_both", 32'hCAFEF00D, 32'hCAFEF00D);

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd7, 5'd8);
        expect_rd("rd7_stored", 32'hCAFEF00D, 32'h8);

        next_cycle();
        drive(1'b1, 1'b1, 5'd8, 32'h0BADC0DE, 5'd9, 5'd8);
        expect_rd("byp_port2", 32'h9, 32'h0BADC0DE);

        next_cycle();
        drive(1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30);
        expect_rd("byp_r31", 32'hFFFFFFFF, 32'h1E);

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd31, 5'd8);
        expect_rd("rd31_rd8", 32'hFFFFFFFF, 32'h0BADC0DE);

        next_cycle();
        drive(1'b0, 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd2);
        expect_rd("rst_no_bypass", 32'h3, 32'h0002FA41);

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3);
        expect_rd("rst_over_write", 32'h2, 32'h3);

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
        expect_rd("rst_restore", 32'h5, 32'h1F);

        next_cycle();
        drive(1'b1, 1'b1, 5'd3, 32'h12345678, 5'd3, 5'd4);
        expect_rd("resume_byp", 32'h12345678, 32'h4);

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd0);
        expect_rd("resume_stored", 32'h12345678, 32'h0);

        for (int i = 0; i < 4; i++) begin
            next_cycle();
            drive(1'b1, 1'b0, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
            expect_rd($sformatf("we0_hold_%0d", i), 32'h9, 32'h9);
        end

        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        repeat (3) @(posedge clock);

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
